// File: rtl/benes_cfg_loader.sv
// Shadow/active configuration loader for the 16x16 Benes network.
// Per-stage switch words are staged in a shadow bank and applied atomically on commit.
module benes_cfg_loader #(
   parameter int N_STAGES     = 7,
   parameter int SW_PER_STAGE = 8,
   parameter int CNT_W        = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cfg_valid,
   input  logic [SW_PER_STAGE-1:0] cfg_data,
   output logic                    cfg_ready,
   input  logic                    commit_req,
   input  logic                    abort,
   output logic [SW_PER_STAGE-1:0] switch_set [0:N_STAGES-1],
   output logic                    cfg_loaded,
   output logic [CNT_W-1:0]        load_cnt,
   output logic                    commit_done,
   output logic                    commit_err,
   output logic [7:0]              cfg_epoch
);

   typedef enum logic [1:0] {
      S_LOAD   = 2'd0,
      S_FULL   = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(N_STAGES - 1);

   state_t                  state_q, state_d;
   logic [SW_PER_STAGE-1:0] shadow_q     [0:N_STAGES-1];
   logic [SW_PER_STAGE-1:0] shadow_d     [0:N_STAGES-1];
   logic [SW_PER_STAGE-1:0] switch_set_q [0:N_STAGES-1];
   logic [SW_PER_STAGE-1:0] switch_set_d [0:N_STAGES-1];
   logic [CNT_W-1:0]        load_cnt_q, load_cnt_d;
   logic [7:0]              epoch_q, epoch_d;
   logic                    commit_done_q, commit_done_d;
   logic                    commit_err_q, commit_err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_LOAD;
         load_cnt_q    <= '0;
         epoch_q       <= '0;
         commit_done_q <= 1'b0;
         commit_err_q  <= 1'b0;
         for (int s = 0; s < N_STAGES; s++) begin
            shadow_q[s]     <= '0;
            switch_set_q[s] <= '0;
         end
      end else begin
         state_q       <= state_d;
         load_cnt_q    <= load_cnt_d;
         epoch_q       <= epoch_d;
         commit_done_q <= commit_done_d;
         commit_err_q  <= commit_err_d;
         for (int s = 0; s < N_STAGES; s++) begin
            shadow_q[s]     <= shadow_d[s];
            switch_set_q[s] <= switch_set_d[s];
         end
      end
   end

   // Abort outranks every other event, including a commit already in flight.
   always_comb begin
      state_d       = state_q;
      load_cnt_d    = load_cnt_q;
      epoch_d       = epoch_q;
      commit_done_d = 1'b0;
      commit_err_d  = 1'b0;
      for (int s = 0; s < N_STAGES; s++) begin
         shadow_d[s]     = shadow_q[s];
         switch_set_d[s] = switch_set_q[s];
      end

      if (abort) begin
         state_d    = S_LOAD;
         load_cnt_d = '0;
         for (int s = 0; s < N_STAGES; s++) begin
            shadow_d[s] = '0;
         end
      end else begin
         case (state_q)
            S_LOAD: begin
               if (commit_req) begin
                  commit_err_d = 1'b1;
               end
               if (cfg_valid) begin
                  for (int s = 0; s < N_STAGES; s++) begin
                     if (load_cnt_q == CNT_W'(s)) begin
                        shadow_d[s] = cfg_data;
                     end
                  end
                  if (load_cnt_q == LAST_STAGE) begin
                     load_cnt_d = '0;
                     state_d    = S_FULL;
                  end else begin
                     load_cnt_d = load_cnt_q + 1'b1;
                  end
               end
            end
            S_FULL: begin
               if (commit_req) begin
                  state_d = S_COMMIT;
               end
            end
            S_COMMIT: begin
               for (int s = 0; s < N_STAGES; s++) begin
                  switch_set_d[s] = shadow_q[s];
                  shadow_d[s]     = '0;
               end
               commit_done_d = 1'b1;
               epoch_d       = epoch_q + 8'd1;
               state_d       = S_LOAD;
            end
            default: begin
               state_d = S_LOAD;
            end
         endcase
      end
   end

   assign cfg_ready   = (state_q == S_LOAD);
   assign cfg_loaded  = (state_q == S_FULL);
   assign load_cnt    = load_cnt_q;
   assign commit_done = commit_done_q;
   assign commit_err  = commit_err_q;
   assign cfg_epoch   = epoch_q;
   assign switch_set  = switch_set_q;

endmodule

// File: tb/tb_benes_cfg_loader.sv
// Directed bench for benes_cfg_loader; committed banks are checked through a scoreboard queue.
module tb_benes_cfg_loader;

   localparam int NS = 7;

   logic       clk;
   logic       rst_n;
   logic       cfg_valid;
   logic [7:0] cfg_data;
   logic       cfg_ready;
   logic       commit_req;
   logic       abort;
   logic [7:0] switch_set [0:NS-1];
   logic       cfg_loaded;
   logic [2:0] load_cnt;
   logic       commit_done;
   logic       commit_err;
   logic [7:0] cfg_epoch;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int exp_done = 0;
   logic [7:0]      exp_epoch = 8'd0;
   logic [NS*8-1:0] sb_q [$];

   benes_cfg_loader #(.N_STAGES(NS), .SW_PER_STAGE(8), .CNT_W(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_valid  (cfg_valid),
      .cfg_data   (cfg_data),
      .cfg_ready  (cfg_ready),
      .commit_req (commit_req),
      .abort      (abort),
      .switch_set (switch_set),
      .cfg_loaded (cfg_loaded),
      .load_cnt   (load_cnt),
      .commit_done(commit_done),
      .commit_err (commit_err),
      .cfg_epoch  (cfg_epoch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [NS*8-1:0] flatSet();
      logic [NS*8-1:0] v;
      for (int s = 0; s < NS; s++) v[s*8 +: 8] = switch_set[s];
      return v;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic c, input logic a);
      cfg_valid  = v;
      cfg_data   = d;
      commit_req = c;
      abort      = a;
      tick();
      cfg_valid  = 1'b0;
      commit_req = 1'b0;
      abort      = 1'b0;
   endtask

   task automatic sendWord(input logic [7:0] d, input bit gaps);
      int n;
      n = 0;
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      cfg_valid = 1'b1;
      cfg_data  = d;
      while (!cfg_ready && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) checkOutput("ready_timeout", 64'(cfg_ready), 64'd1);
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic doCommit(input logic [NS*8-1:0] exp);
      int n;
      n = 0;
      while (!cfg_loaded && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) checkOutput("loaded_timeout", 64'(cfg_loaded), 64'd1);
      sb_q.push_back(exp);
      exp_done++;
      commit_req = 1'b1;
      tick();
      commit_req = 1'b0;
      checkOutput("commit_state_ready", 64'(cfg_ready), 64'd0);
      tick();
      exp_epoch = exp_epoch + 8'd1;
      checkOutput("commit_switch_set", 64'(flatSet()), 64'(exp));
      checkOutput("commit_done_pulse", 64'(commit_done), 64'd1);
      checkOutput("commit_epoch", 64'(cfg_epoch), 64'(exp_epoch));
   endtask

   always @(negedge clk) begin
      if (rst_n && commit_done) begin
         done_cnt++;
         checkOutput("sb_pending", 64'(sb_q.size() > 0), 64'd1);
         if (sb_q.size() > 0) checkOutput("sb_switch_set", 64'(flatSet()), 64'(sb_q.pop_front()));
      end
   end

   initial begin
      logic [NS*8-1:0] exp;
      logic [NS*8-1:0] prev;
      logic [7:0]      w;

      rst_n = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00; commit_req = 1'b0; abort = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      $display("[TB] reset state");
      checkOutput("rst_switch_set", 64'(flatSet()), 64'd0);
      checkOutput("rst_cfg_ready", 64'(cfg_ready), 64'd1);
      checkOutput("rst_cfg_loaded", 64'(cfg_loaded), 64'd0);
      checkOutput("rst_load_cnt", 64'(load_cnt), 64'd0);
      checkOutput("rst_epoch", 64'(cfg_epoch), 64'd0);
      checkOutput("rst_done_err", 64'({commit_done, commit_err}), 64'd0);

      $display("[TB] back-to-back load of one-hot words");
      for (int s = 0; s < NS; s++) begin
         checkOutput("load_cnt_step", 64'(load_cnt), 64'(s));
         cfg_valid = 1'b1;
         cfg_data  = 8'(1 << s);
         exp[s*8 +: 8] = 8'(1 << s);
         tick();
      end
      cfg_data = 8'hAA;
      checkOutput("full_loaded", 64'(cfg_loaded), 64'd1);
      checkOutput("full_ready", 64'(cfg_ready), 64'd0);
      checkOutput("full_load_cnt", 64'(load_cnt), 64'd0);
      checkOutput("full_switch_unchanged", 64'(flatSet()), 64'd0);
      tick();
      checkOutput("stall_load_cnt", 64'(load_cnt), 64'd0);
      doCommit(exp);
      checkOutput("post_commit_ready", 64'(cfg_ready), 64'd1);
      tick();
      cfg_valid = 1'b0;
      checkOutput("held_word_accepted", 64'(load_cnt), 64'd1);
      checkOutput("done_single_pulse", 64'(commit_done), 64'd0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("abort_clears_cnt", 64'(load_cnt), 64'd0);

      $display("[TB] early commit request");
      prev = flatSet();
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("err_at_cnt0", 64'(commit_err), 64'd1);
      for (int s = 0; s < 3; s++) begin
         w = 8'(8'h11 * (s + 1));
         exp[s*8 +: 8] = w;
         sendWord(w, 1'b0);
      end
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("err_pulse", 64'(commit_err), 64'd1);
      checkOutput("err_load_cnt", 64'(load_cnt), 64'd3);
      checkOutput("err_switch_unchanged", 64'(flatSet()), 64'(prev));
      tick();
      checkOutput("err_one_cycle", 64'(commit_err), 64'd0);
      for (int s = 3; s < NS; s++) begin
         w = 8'(8'h11 * (s + 1));
         exp[s*8 +: 8] = w;
         sendWord(w, 1'b0);
      end
      doCommit(exp);

      $display("[TB] abort during load");
      prev = flatSet();
      for (int s = 0; s < 5; s++) sendWord(8'h5A, 1'b0);
      applyStimulus(1'b1, 8'hC3, 1'b0, 1'b1);
      checkOutput("abort_drop_cnt", 64'(load_cnt), 64'd0);
      checkOutput("abort_switch_unchanged", 64'(flatSet()), 64'(prev));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
      checkOutput("abort_beats_commit_err", 64'(commit_err), 64'd0);
      for (int s = 0; s < NS; s++) begin
         exp[s*8 +: 8] = 8'hFF;
         sendWord(8'hFF, 1'b0);
      end
      doCommit(exp);

      $display("[TB] abort inside commit cycle");
      prev = flatSet();
      for (int s = 0; s < NS; s++) sendWord(8'h3C, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("pre_abort_in_commit", 64'(cfg_ready), 64'd0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("abort_commit_switch", 64'(flatSet()), 64'(prev));
      checkOutput("abort_commit_done", 64'(commit_done), 64'd0);
      checkOutput("abort_commit_epoch", 64'(cfg_epoch), 64'(exp_epoch));
      checkOutput("abort_commit_ready", 64'(cfg_ready), 64'd1);

      $display("[TB] epoch wrap");
      while (exp_epoch != 8'd255) begin
         for (int s = 0; s < NS; s++) begin
            w = 8'($urandom);
            exp[s*8 +: 8] = w;
            sendWord(w, 1'b0);
         end
         doCommit(exp);
      end
      checkOutput("epoch_255", 64'(cfg_epoch), 64'd255);
      for (int s = 0; s < NS; s++) begin
         w = 8'($urandom);
         exp[s*8 +: 8] = w;
         sendWord(w, 1'b0);
      end
      doCommit(exp);
      checkOutput("epoch_wrap_zero", 64'(cfg_epoch), 64'd0);

      $display("[TB] reset mid-load with gaps");
      for (int s = 0; s < 4; s++) sendWord(8'($urandom), 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_switch", 64'(flatSet()), 64'd0);
      checkOutput("async_rst_cnt", 64'(load_cnt), 64'd0);
      checkOutput("async_rst_epoch", 64'(cfg_epoch), 64'd0);
      checkOutput("async_rst_ready", 64'(cfg_ready), 64'd1);
      exp_epoch = 8'd0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      for (int s = 0; s < NS; s++) begin
         w = 8'($urandom);
         exp[s*8 +: 8] = w;
         sendWord(w, 1'b1);
      end
      doCommit(exp);
      tick();
      tick();

      checkOutput("sb_drained", 64'(sb_q.size()), 64'd0);
      checkOutput("done_count", 64'(done_cnt), 64'(exp_done));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
